mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter REG_NUM_BITWIDTH, default 5, destination register index width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (in, 1), ALUresult (in, WORD), finalReadData2 (in, WORD), funct3 (in, 3), memRead (in, 1), memWrite (in, 1), memToReg (in, 1), regWrite (in, 1), rd (in, REG_NUM_BITWIDTH): EX/MEM stage inputs.
REQ-006 SHALL have bus ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, WORD), mem_wdata (out, WORD), mem_be (out, WORD/8), mem_rdata (in, WORD), mem_ack (in, 1).
REQ-007 SHALL have outputs stall (1), wb_valid (1), wb_regWrite (1), wb_rd (REG_NUM_BITWIDTH), regWriteData (WORD), misaligned (1).

Function
REQ-008 SHALL implement FSM states IDLE and WAIT.
REQ-009 SHALL, in IDLE with in_valid=1 and memRead=memWrite=0, register regWriteData=ALUresult, wb_rd, wb_regWrite, and set wb_valid=1 on the next edge (latency 1).
REQ-010 SHALL, in IDLE with in_valid=1 and an aligned memRead or memWrite, register mem_addr, mem_we, mem_wdata, mem_be, funct3, rd, memToReg, regWrite, raise mem_req on the next edge and enter WAIT.
REQ-011 SHALL hold all bus outputs stable while mem_req=1 and mem_ack=0.
REQ-012 SHALL, in WAIT with mem_ack=1, drop mem_req, return to IDLE, and on that same edge register the write-back result with wb_valid=1 (latency = ack cycle + 1).
REQ-013 SHALL drive stall=1 combinationally whenever state=WAIT, or state=IDLE with in_valid=1 and a memory op.
REQ-014 SHALL ignore in_valid while stall=1; upstream holds inputs.
REQ-015 SHALL ignore mem_ack while in IDLE.
REQ-016 SHALL pulse wb_valid for exactly one cycle per accepted instruction; wb_valid=0 otherwise.
REQ-017 SHALL format loads from mem_rdata by funct3: 000 LB, 001 LH, 010 LW (sign-extended when WORD=64), 100 LBU, 101 LHU, 110 LWU, 011 LD; byte lane selected by mem_addr low bits.
REQ-018 SHALL drive stores: funct3 000 SB, 001 SH, 010 SW, 011 SD; data replicated across lanes; mem_be one-hot/pair/quad/all at the addressed lane.
REQ-019 SHALL word-align mem_addr (low log2(WORD/8) bits cleared).
REQ-020 SHALL treat as misaligned: halfword at odd address, word not 4-aligned, doubleword not 8-aligned, and 011/110 when WORD=32.
REQ-021 SHALL, for a misaligned op, issue no request, stay in IDLE, and on the next edge pulse misaligned=1 and wb_valid=1 with wb_regWrite=0.
REQ-022 SHALL select regWriteData = memToReg ? formatted load : latched ALUresult.
REQ-023 SHALL force wb_regWrite=0 for stores.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force state=IDLE and mem_req, mem_we, mem_be, wb_valid, wb_regWrite, misaligned, regWriteData, wb_rd, mem_addr, mem_wdata to 0.
REQ-025 SHALL abandon an in-flight WAIT on reset; an ack arriving after reset is ignored.

Structure
REQ-026 SHALL place funct3 load/store encodings and FSM state encoding in shared package riscv_pkg.
REQ-027 SHALL implement load extraction/extension as sub-module load_formatter (combinational).

Verification
REQ-028 SHALL cover ADD pass-through: ALUresult=0x0000_1234, regWrite=1, rd=5 -> next cycle wb_valid=1, regWriteData=0x1234, stall never 1.
REQ-029 SHALL cover LB at 0x103, mem_rdata=0x80FF_FFFF, ack after 3 wait cycles -> stall 4 cycles, regWriteData=0xFFFF_FF80.
REQ-030 SHALL cover SH at 0x102, data 0xABCD -> mem_addr=0x100, mem_be=1100, mem_wdata=0xABCD_ABCD, wb_regWrite=0.
REQ-031 SHALL cover LW at 0x101 -> mem_req never 1, misaligned pulse one cycle, wb_regWrite=0.
REQ-032 SHALL cover rst_n low during WAIT, then mem_ack=1 -> mem_req=0 immediately, no wb_valid.
REQ-033 SHALL cover WORD=64 LD at 0x8, mem_rdata=0x0123_4567_89AB_CDEF, immediate ack -> regWriteData equals mem_rdata.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the memory stage.
//   - funct3 encodings for loads and stores
//   - FSM state encoding for mem_stage
//   - access_misaligned(): decides whether an access must be refused
package riscv_pkg;

  // funct3 load/store size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // mem_stage FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Returns 1 when the access cannot be issued: natural alignment is violated,
  // the size is not available on a 32-bit datapath (LD/SD/LWU), or a store
  // uses one of the unsigned (load-only) encodings.
  function automatic logic access_misaligned(input logic [2:0] f3,
                                             input logic       is_store,
                                             input logic [2:0] addr_lo,
                                             input logic       wide);
    logic bad;
    bad = is_store && f3[2];
    case (f3[1:0])
      2'b00:   bad = bad;
      2'b01:   bad = bad || addr_lo[0];
      2'b10:   bad = bad || (addr_lo[1:0] != 2'b00) || (f3[2] && !wide);
      default: bad = bad || (addr_lo != 3'b000) || f3[2] || !wide;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational load data extraction and extension.
//   rdata  : raw bus read word
//   offset : byte lane of the access within the word
//   funct3 : load size/sign encoding
//   data   : lane-aligned, sign/zero-extended result
module load_formatter
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = 32
) (
  input  logic [WORD_BITWIDTH-1:0]             rdata,
  input  logic [$clog2(WORD_BITWIDTH/8)-1:0]   offset,
  input  logic [2:0]                           funct3,
  output logic [WORD_BITWIDTH-1:0]             data
);

  logic [WORD_BITWIDTH-1:0] lane;

  always_comb begin
    // Bring the addressed byte lane down to bit 0 before extending.
    lane = rdata >> {offset, 3'b000};
    data = '0;
    case (funct3)
      F3_B:    data = WORD_BITWIDTH'($signed(lane[7:0]));
      F3_H:    data = WORD_BITWIDTH'($signed(lane[15:0]));
      F3_W:    data = WORD_BITWIDTH'($signed(lane[31:0]));
      F3_BU:   data = WORD_BITWIDTH'(lane[7:0]);
      F3_HU:   data = WORD_BITWIDTH'(lane[15:0]);
      F3_WU:   data = WORD_BITWIDTH'(lane[31:0]);
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a simple req/ack data bus.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid .. rd        : EX/MEM stage inputs
//   mem_req .. mem_be     : bus request (word-aligned address, lane strobes)
//   mem_rdata, mem_ack    : bus response
//   stall                 : upstream must hold its inputs
//   wb_valid, wb_regWrite,
//   wb_rd, regWriteData   : write-back result, one-cycle pulse per instruction
//   misaligned            : pulses with wb_valid for a refused access
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH    = 32,
  parameter int unsigned REG_NUM_BITWIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WORD_BITWIDTH-1:0]      ALUresult,
  input  logic [WORD_BITWIDTH-1:0]      finalReadData2,
  input  logic [2:0]                    funct3,
  input  logic                          memRead,
  input  logic                          memWrite,
  input  logic                          memToReg,
  input  logic                          regWrite,
  input  logic [REG_NUM_BITWIDTH-1:0]   rd,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [WORD_BITWIDTH-1:0]      mem_addr,
  output logic [WORD_BITWIDTH-1:0]      mem_wdata,
  output logic [WORD_BITWIDTH/8-1:0]    mem_be,
  input  logic [WORD_BITWIDTH-1:0]      mem_rdata,
  input  logic                          mem_ack,
  output logic                          stall,
  output logic                          wb_valid,
  output logic                          wb_regWrite,
  output logic [REG_NUM_BITWIDTH-1:0]   wb_rd,
  output logic [WORD_BITWIDTH-1:0]      regWriteData,
  output logic                          misaligned
);

  localparam int unsigned BE_BITS  = WORD_BITWIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BE_BITS);

  logic [0:0]                  state;
  logic [2:0]                  f3_q;
  logic [OFF_BITS-1:0]         off_q;
  logic [REG_NUM_BITWIDTH-1:0] rd_q;
  logic                        mem_to_reg_q;
  logic                        reg_write_q;
  logic [WORD_BITWIDTH-1:0]    alu_q;

  logic                        mem_op;
  logic                        bad_access;
  logic [OFF_BITS-1:0]         offset_in;
  logic [WORD_BITWIDTH-1:0]    aligned_addr;
  logic [WORD_BITWIDTH-1:0]    st_data;
  logic [BE_BITS-1:0]          st_be;
  logic [WORD_BITWIDTH-1:0]    load_data;

  always_comb begin
    mem_op       = memRead | memWrite;
    bad_access   = access_misaligned(funct3, memWrite, ALUresult[2:0],
                                     WORD_BITWIDTH == 64);
    offset_in    = ALUresult[OFF_BITS-1:0];
    aligned_addr = {ALUresult[WORD_BITWIDTH-1:OFF_BITS], OFF_BITS'(0)};
    stall        = (state == ST_WAIT) || (in_valid && mem_op);
  end

  // Store data is replicated across all lanes so the slave can pick any lane;
  // mem_be marks the bytes actually written.
  always_comb begin
    st_data = finalReadData2;
    st_be   = '1;
    case (funct3[1:0])
      2'b00: begin
        st_data = {BE_BITS{finalReadData2[7:0]}};
        st_be   = BE_BITS'(1) << offset_in;
      end
      2'b01: begin
        st_data = {(BE_BITS/2){finalReadData2[15:0]}};
        st_be   = BE_BITS'(2'b11) << offset_in;
      end
      2'b10: begin
        st_data = {(BE_BITS/4){finalReadData2[31:0]}};
        st_be   = BE_BITS'(4'hF) << offset_in;
      end
      default: begin
        st_data = finalReadData2;
        st_be   = '1;
      end
    endcase
  end

  load_formatter #(
    .WORD_BITWIDTH (WORD_BITWIDTH)
  ) u_load_formatter (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_q        <= '0;
      wb_valid     <= 1'b0;
      wb_regWrite  <= 1'b0;
      wb_rd        <= '0;
      regWriteData <= '0;
      misaligned   <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          // mem_ack is deliberately not looked at here.
          if (in_valid) begin
            if (!mem_op) begin
              regWriteData <= ALUresult;
              wb_rd        <= rd;
              wb_regWrite  <= regWrite;
              wb_valid     <= 1'b1;
            end else if (bad_access) begin
              wb_rd        <= rd;
              wb_regWrite  <= 1'b0;
              wb_valid     <= 1'b1;
              misaligned   <= 1'b1;
            end else begin
              mem_req      <= 1'b1;
              mem_we       <= memWrite;
              mem_addr     <= aligned_addr;
              mem_wdata    <= st_data;
              mem_be       <= st_be;
              f3_q         <= funct3;
              off_q        <= offset_in;
              rd_q         <= rd;
              mem_to_reg_q <= memToReg;
              reg_write_q  <= regWrite;
              alu_q        <= ALUresult;
              state        <= ST_WAIT;
            end
          end
        end
        default: begin
          // Bus outputs are only written on entry, so they hold until ack.
          if (mem_ack) begin
            mem_req      <= 1'b0;
            state        <= ST_IDLE;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_q;
            wb_regWrite  <= reg_write_q & ~mem_we;
            regWriteData <= mem_to_reg_q ? load_data : alu_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage (32- and 64-bit).
module tb_mem_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        in_valid, memRead, memWrite, memToReg, regWrite, mem_ack;
  logic [31:0] ALUresult, finalReadData2, mem_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        mem_req, mem_we, stall, wb_valid, wb_regWrite, misaligned;
  logic [31:0] mem_addr, mem_wdata, regWriteData;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  // 64-bit instance signals
  logic        w_in_valid, w_memRead, w_memWrite, w_memToReg, w_regWrite, w_mem_ack;
  logic [63:0] w_ALUresult, w_finalReadData2, w_mem_rdata;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_mem_req, w_mem_we, w_stall, w_wb_valid, w_wb_regWrite, w_misaligned;
  logic [63:0] w_mem_addr, w_mem_wdata, w_regWriteData;
  logic [7:0]  w_mem_be;
  logic [4:0]  w_wb_rd;

  mem_stage #(.WORD_BITWIDTH(32), .REG_NUM_BITWIDTH(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUresult(ALUresult),
    .finalReadData2(finalReadData2), .funct3(funct3), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
    .regWriteData(regWriteData), .misaligned(misaligned)
  );

  mem_stage #(.WORD_BITWIDTH(64), .REG_NUM_BITWIDTH(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .ALUresult(w_ALUresult),
    .finalReadData2(w_finalReadData2), .funct3(w_funct3), .memRead(w_memRead),
    .memWrite(w_memWrite), .memToReg(w_memToReg), .regWrite(w_regWrite), .rd(w_rd),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_be(w_mem_be), .mem_rdata(w_mem_rdata),
    .mem_ack(w_mem_ack), .stall(w_stall), .wb_valid(w_wb_valid),
    .wb_regWrite(w_wb_regWrite), .wb_rd(w_wb_rd), .regWriteData(w_regWriteData),
    .misaligned(w_misaligned)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] data;
    logic        mis;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic rw, input logic [63:0] d,
                      input logic mis, input logic cd);
    wb_exp_t e;
    e.rd = r; e.rw = rw; e.data = d; e.mis = mis; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] r, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd);
    in_valid = 1'b1; rd = r; memRead = mr; memWrite = mw; memToReg = m2r;
    regWrite = rw; funct3 = f3; ALUresult = alu; finalReadData2 = wd;
  endtask

  // Compare the oldest expected write-back against the 32-bit DUT now,
  // allowing up to 'budget' further cycles for wb_valid.
  task automatic wait_wb(input int budget);
    int lat;
    wb_exp_t e;
    lat = 0;
    while (wb_valid !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    chk("wb_valid", {63'd0, wb_valid}, 64'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
      chk("wb_regWrite", {63'd0, wb_regWrite}, {63'd0, e.rw});
      chk("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
      if (e.chk_data) chk("regWriteData", {32'd0, regWriteData}, e.data);
    end
  endtask

  // Inputs for a memory op are already driven; runs the bus handshake with
  // ack asserted on the n_wait-th request cycle and counts stall cycles.
  task automatic mem_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int n_wait,
                         input logic [31:0] rdata, output int stalls);
    stalls = 0;
    #1 if (stall) stalls++;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < n_wait; c++) begin
      chk("mem_req", {63'd0, mem_req}, 64'd1);
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, a});
      chk("mem_we", {63'd0, mem_we}, {63'd0, we});
      if (we) begin
        chk("mem_be", {60'd0, mem_be}, {60'd0, be});
        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
      end
      if (stall) stalls++;
      ALUresult = $urandom;
      finalReadData2 = $urandom;
      if (c == n_wait - 1) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("mem_req_drop", {63'd0, mem_req}, 64'd0);
  endtask

  task automatic refused_op(input logic [4:0] r, input logic [2:0] f3,
                            input logic [31:0] a);
    drive(r, 1'b1, 1'b0, 1'b1, 1'b1, f3, a, 32'd0);
    push(r, 1'b0, 64'd0, 1'b1, 1'b0);
    #1 chk("mis_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mis_no_req", {63'd0, mem_req}, 64'd0);
    wait_wb(0);
    @(negedge clk);
    chk("mis_pulse", {63'd0, misaligned}, 64'd0);
    chk("mis_wb_pulse", {63'd0, wb_valid}, 64'd0);
    chk("mis_no_req2", {63'd0, mem_req}, 64'd0);
  endtask

  task automatic w_load(input logic [4:0] r, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] a_exp, input logic [63:0] rdata,
                        input logic [63:0] want);
    wb_exp_t e;
    w_in_valid = 1'b1; w_memRead = 1'b1; w_memWrite = 1'b0; w_memToReg = 1'b1;
    w_regWrite = 1'b1; w_rd = r; w_funct3 = f3; w_ALUresult = a;
    push(r, 1'b1, want, 1'b0, 1'b1);
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("w_mem_req", {63'd0, w_mem_req}, 64'd1);
    chk("w_mem_addr", w_mem_addr, a_exp);
    w_mem_ack = 1'b1;
    w_mem_rdata = rdata;
    @(negedge clk);
    w_mem_ack = 1'b0;
    chk("w_wb_valid", {63'd0, w_wb_valid}, 64'd1);
    chk("w_mem_req_drop", {63'd0, w_mem_req}, 64'd0);
    if (sb.size() == 0) begin
      chk("w_sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("w_wb_rd", {59'd0, w_wb_rd}, {59'd0, e.rd});
      chk("w_wb_regWrite", {63'd0, w_wb_regWrite}, {63'd0, e.rw});
      chk("w_regWriteData", w_regWriteData, e.data);
    end
    @(negedge clk);
    chk("w_wb_pulse", {63'd0, w_wb_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    rst_n = 1'b0;
    in_valid = 0; memRead = 0; memWrite = 0; memToReg = 0; regWrite = 0; mem_ack = 0;
    ALUresult = '0; finalReadData2 = '0; mem_rdata = '0; funct3 = '0; rd = '0;
    w_in_valid = 0; w_memRead = 0; w_memWrite = 0; w_memToReg = 0; w_regWrite = 0;
    w_mem_ack = 0; w_ALUresult = '0; w_finalReadData2 = '0; w_mem_rdata = '0;
    w_funct3 = '0; w_rd = '0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_regWriteData", {32'd0, regWriteData}, 64'd0);
    chk("rst_mem_be", {60'd0, mem_be}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_w_regWriteData", w_regWriteData, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD pass-through, latency 1, no stall
    drive(5'd5, 0, 0, 0, 1, F3_B, 32'h0000_1234, 32'd0);
    push(5'd5, 1'b1, 64'h1234, 1'b0, 1'b1);
    #1 chk("add_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_stall2", {63'd0, stall}, 64'd0);
    wait_wb(0);
    @(negedge clk);
    chk("add_wb_pulse", {63'd0, wb_valid}, 64'd0);

    // LB at 0x103, ack on third request cycle
    drive(5'd7, 1, 0, 1, 1, F3_B, 32'h0000_0103, 32'd0);
    push(5'd7, 1'b1, 64'hFFFF_FF80, 1'b0, 1'b1);
    mem_txn(32'h100, 1'b0, 4'b0000, 32'd0, 3, 32'h80FF_FFFF, stalls);
    wait_wb(0);
    chk("lb_stall_cycles", 64'(stalls), 64'd4);
    @(negedge clk);
    chk("lb_wb_pulse", {63'd0, wb_valid}, 64'd0);

    // LHU at 0x102: upper halfword, zero-extended
    drive(5'd8, 1, 0, 1, 1, F3_HU, 32'h0000_0102, 32'd0);
    push(5'd8, 1'b1, 64'h0000_8001, 1'b0, 1'b1);
    mem_txn(32'h100, 1'b0, 4'b0000, 32'd0, 2, 32'h8001_2345, stalls);
    wait_wb(0);
    chk("lhu_stall_cycles", 64'(stalls), 64'd3);

    // SH at 0x102
    drive(5'd9, 0, 1, 0, 1, F3_H, 32'h0000_0102, 32'h0000_ABCD);
    push(5'd9, 1'b0, 64'h102, 1'b0, 1'b1);
    mem_txn(32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD, 1, 32'd0, stalls);
    wait_wb(0);
    chk("sh_stall_cycles", 64'(stalls), 64'd2);

    // SB at 0x101
    drive(5'd10, 0, 1, 0, 1, F3_B, 32'h0000_0101, 32'h1234_565A);
    push(5'd10, 1'b0, 64'h101, 1'b0, 1'b1);
    mem_txn(32'h100, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1, 32'd0, stalls);
    wait_wb(0);

    // Refused accesses: LW at 0x101, LD on a 32-bit datapath
    refused_op(5'd11, F3_W, 32'h0000_0101);
    refused_op(5'd13, F3_D, 32'h0000_0100);

    // Reset during WAIT, then a stale ack
    drive(5'd12, 1, 0, 1, 1, F3_W, 32'h0000_0200, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_mem_req", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1 chk("rw_req_cleared", {63'd0, mem_req}, 64'd0);
    chk("rw_stall_cleared", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw_no_wb", {63'd0, wb_valid}, 64'd0);
    chk("rw_no_req", {63'd0, mem_req}, 64'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rw_no_wb2", {63'd0, wb_valid}, 64'd0);

    // 64-bit datapath: LD at 0x8, LW (sign-extended) at 0x4
    w_load(5'd3, F3_D, 64'h8, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    w_load(5'd4, F3_W, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
